// File: rtl/run_detector_pkg.sv
// run_detector_pkg: shared state encoding and width helper for the run-of-ones
// detector.
//   state_e   - per-channel FSM state (S_IDLE / S_COUNT / S_HIT)
//   cnt_w()   - run counter width, never narrower than 1 bit
package run_detector_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_COUNT = 2'b01,
    S_HIT   = 2'b10
  } state_e;

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/run_detector_if.sv
// run_detector_if: groups the sample-side controls and the status outputs of
// run_detector.
//   en        - sample enable (hold all channels when 0)
//   clr       - synchronous clear of all event counters
//   bi        - per-channel control inputs
//   bo_pulse  - per-channel one-cycle hit pulse
//   bo_active - per-channel level, high while in S_HIT
//   evt_count - flattened saturating counters, channel i at [i*EVT_W +: EVT_W]
interface run_detector_if #(
  parameter int CHANNELS = 2,
  parameter int EVT_W    = 8
);
  logic                      en;
  logic                      clr;
  logic [CHANNELS-1:0]       bi;
  logic [CHANNELS-1:0]       bo_pulse;
  logic [CHANNELS-1:0]       bo_active;
  logic [CHANNELS*EVT_W-1:0] evt_count;

  modport master (output en, clr, bi, input bo_pulse, bo_active, evt_count);
  modport slave  (input en, clr, bi, output bo_pulse, bo_active, evt_count);
endinterface

// File: rtl/run_detector_ch.sv
// run_detector_ch: one detector channel. Counts consecutive enabled 1-samples
// of bi_i, flags a hit when the run reaches RUN_LEN, keeps a saturating event
// counter.
//   clk, reset - clock, async active-high reset
//   en_i       - sample enable
//   clr_i      - clear event counter (wins over a simultaneous hit)
//   bi_i       - control input
//   pulse_o    - hit pulse (same cycle if MEALY, else one cycle later)
//   active_o   - high while in S_HIT
//   evt_o      - saturating hit counter
module run_detector_ch
  import run_detector_pkg::*;
#(
  parameter int RUN_LEN = 3,
  parameter int MEALY   = 1,
  parameter int REPEAT  = 0,
  parameter int EVT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             bi_i,
  output logic             pulse_o,
  output logic             active_o,
  output logic [EVT_W-1:0] evt_o
);

  localparam int            CW   = cnt_w(RUN_LEN);
  localparam logic [CW-1:0] LAST = CW'(RUN_LEN - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [EVT_W-1:0] evt_q, evt_d;
  logic             hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      evt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      evt_q   <= evt_d;
    end
  end

  // hit is already qualified by en_i, so downstream logic needs no extra gate.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hit     = 1'b0;
    if (en_i) begin
      if (!bi_i) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        case (state_q)
          S_IDLE, S_COUNT: begin
            if (cnt_q == LAST) begin
              hit     = 1'b1;
              state_d = S_HIT;
              cnt_d   = (REPEAT != 0) ? '0 : cnt_q;
            end else begin
              state_d = S_COUNT;
              cnt_d   = cnt_q + 1'b1;
            end
          end
          S_HIT: begin
            // Without REPEAT the run is already reported; just sit here.
            if (REPEAT != 0) begin
              if (cnt_q == LAST) begin
                hit   = 1'b1;
                cnt_d = '0;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end
          end
          default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    evt_d = evt_q;
    if (clr_i)                 evt_d = '0;
    else if (hit && evt_q != '1) evt_d = evt_q + 1'b1;
  end

  generate
    if (MEALY != 0) begin : g_mealy
      // Reset forces the state to S_IDLE, but with RUN_LEN=1 an idle channel
      // would still hit combinationally; mask it while reset is held.
      assign pulse_o = hit & ~reset;
    end else begin : g_moore
      logic pulse_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) pulse_q <= 1'b0;
        else       pulse_q <= hit;
      end
      assign pulse_o = pulse_q;
    end
  endgenerate

  assign active_o = (state_q == S_HIT);
  assign evt_o    = evt_q;

endmodule

// File: rtl/run_detector.sv
// run_detector: CHANNELS independent run-of-ones detectors sharing en/clr.
//   clk, reset - clock, async active-high reset
//   bus        - run_detector_if slave: en, clr, bi in; bo_pulse, bo_active,
//                evt_count out
module run_detector
  import run_detector_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int RUN_LEN  = 3,
  parameter int MEALY    = 1,
  parameter int REPEAT   = 0,
  parameter int EVT_W    = 8
) (
  input logic           clk,
  input logic           reset,
  run_detector_if.slave bus
);

  logic [CHANNELS-1:0]             pulse_w, active_w;
  logic [CHANNELS-1:0][EVT_W-1:0]  evt_w;

  generate
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      run_detector_ch #(
        .RUN_LEN(RUN_LEN), .MEALY(MEALY), .REPEAT(REPEAT), .EVT_W(EVT_W)
      ) u_ch (
        .clk     (clk),
        .reset   (reset),
        .en_i    (bus.en),
        .clr_i   (bus.clr),
        .bi_i    (bus.bi[g]),
        .pulse_o (pulse_w[g]),
        .active_o(active_w[g]),
        .evt_o   (evt_w[g])
      );
    end
  endgenerate

  assign bus.bo_pulse  = pulse_w;
  assign bus.bo_active = active_w;
  assign bus.evt_count = evt_w;

endmodule

// File: tb/tb_run_detector.sv
// Bench for run_detector: four configurations driven with identical stimulus.
//   cfg0 defaults, cfg1 REPEAT=1, cfg2 MEALY=0, cfg3 RUN_LEN=1 REPEAT=1 EVT_W=2
module tb_run_detector;

  logic       clk = 1'b0;
  logic       reset;
  logic       en, clr;
  logic [1:0] bi;

  always #5 clk = ~clk;

  run_detector_if #(.CHANNELS(2), .EVT_W(8)) if0 ();
  run_detector_if #(.CHANNELS(2), .EVT_W(8)) if1 ();
  run_detector_if #(.CHANNELS(2), .EVT_W(8)) if2 ();
  run_detector_if #(.CHANNELS(2), .EVT_W(2)) if3 ();

  assign if0.en = en; assign if0.clr = clr; assign if0.bi = bi;
  assign if1.en = en; assign if1.clr = clr; assign if1.bi = bi;
  assign if2.en = en; assign if2.clr = clr; assign if2.bi = bi;
  assign if3.en = en; assign if3.clr = clr; assign if3.bi = bi;

  run_detector #(.CHANNELS(2), .RUN_LEN(3), .MEALY(1), .REPEAT(0), .EVT_W(8))
    u0 (.clk(clk), .reset(reset), .bus(if0));
  run_detector #(.CHANNELS(2), .RUN_LEN(3), .MEALY(1), .REPEAT(1), .EVT_W(8))
    u1 (.clk(clk), .reset(reset), .bus(if1));
  run_detector #(.CHANNELS(2), .RUN_LEN(3), .MEALY(0), .REPEAT(0), .EVT_W(8))
    u2 (.clk(clk), .reset(reset), .bus(if2));
  run_detector #(.CHANNELS(2), .RUN_LEN(1), .MEALY(1), .REPEAT(1), .EVT_W(2))
    u3 (.clk(clk), .reset(reset), .bus(if3));

  logic [1:0]  po [4];
  logic [1:0]  ao [4];
  logic [15:0] eo [4];
  assign po[0] = if0.bo_pulse;  assign ao[0] = if0.bo_active;  assign eo[0] = if0.evt_count;
  assign po[1] = if1.bo_pulse;  assign ao[1] = if1.bo_active;  assign eo[1] = if1.evt_count;
  assign po[2] = if2.bo_pulse;  assign ao[2] = if2.bo_active;  assign eo[2] = if2.evt_count;
  assign po[3] = if3.bo_pulse;  assign ao[3] = if3.bo_active;  assign eo[3] = {12'b0, if3.evt_count};

  // Reference model: run length of consecutive enabled ones per channel.
  localparam int RL   [4] = '{3, 3, 3, 1};
  localparam bit RP   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  localparam bit ML   [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  localparam int EW   [4] = '{8, 8, 8, 2};
  localparam int EMAX [4] = '{255, 255, 255, 3};

  int run  [4][2];
  int evt  [4][2];
  bit phit [4][2];

  int nchk = 0;
  int nfail = 0;

  function automatic bit mhit(int c, int ch, bit e, bit b);
    int r;
    if (!e || !b) return 1'b0;
    r = run[c][ch] + 1;
    return RP[c] ? (r % RL[c] == 0) : (r == RL[c]);
  endfunction

  function automatic int evt_of(int c, int ch);
    return int'((eo[c] >> (ch * EW[c])) & 16'(EMAX[c]));
  endfunction

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; clr = 1'b0; bi = 2'b00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int c = 0; c < 4; c++)
      for (int ch = 0; ch < 2; ch++) begin
        run[c][ch] = 0; evt[c][ch] = 0; phit[c][ch] = 1'b0;
      end
  endtask

  task automatic put(input bit e, input bit c, input logic [1:0] b);
    en = e; clr = c; bi = b;
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; clr = 1'b0; bi = 2'b11;
    #3;
    for (int c = 0; c < 4; c++) begin
      nchk++;
      if (po[c] !== 2'b00 || ao[c] !== 2'b00 || eo[c] !== 16'h0) begin
        nfail++;
        $display("FAIL reset cfg%0d pulse=%b active=%b evt=%h required 0/0/0", c, po[c], ao[c], eo[c]);
      end
    end
    do_reset();
  endtask

  task automatic test_default();
    do_reset();
    for (int k = 1; k <= 7; k++) begin
      put(1'b1, 1'b0, {1'b0, k <= 5});
      nchk++;
      if (po[0] !== {1'b0, k == 3}) begin
        nfail++; $display("FAIL default_pulse k=%0d got %b required %b", k, po[0], {1'b0, k == 3});
      end
      nchk++;
      if (ao[0] !== {1'b0, k >= 4 && k <= 6}) begin
        nfail++; $display("FAIL default_active k=%0d got %b required %b", k, ao[0], {1'b0, k >= 4 && k <= 6});
      end
      nchk++;
      if (po[2] !== {1'b0, k == 4}) begin
        nfail++; $display("FAIL moore_pulse k=%0d got %b required %b", k, po[2], {1'b0, k == 4});
      end
      nchk++;
      if (eo[2][7:0] !== ((k >= 4) ? 8'd1 : 8'd0)) begin
        nfail++; $display("FAIL moore_evt k=%0d got %0d required %0d", k, eo[2][7:0], k >= 4);
      end
      nxt();
    end
    nchk++;
    if (eo[0] !== 16'h0001) begin
      nfail++; $display("FAIL default_evt got %h required 0001", eo[0]);
    end
  endtask

  task automatic test_gap();
    bit pat [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    for (int k = 1; k <= 7; k++) begin
      put(1'b1, 1'b0, {(k <= 6) ? pat[k-1] : 1'b0, 1'b0});
      nchk++;
      if (po[0] !== {k == 6, 1'b0}) begin
        nfail++; $display("FAIL gap_pulse k=%0d got %b required %b", k, po[0], {k == 6, 1'b0});
      end
      nchk++;
      if (ao[0] !== {k == 7, 1'b0}) begin
        nfail++; $display("FAIL gap_active k=%0d got %b required %b", k, ao[0], {k == 7, 1'b0});
      end
      nxt();
    end
    nchk++;
    if (eo[0] !== 16'h0100) begin
      nfail++; $display("FAIL gap_evt got %h required 0100", eo[0]);
    end
  endtask

  task automatic test_repeat();
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      put(1'b1, 1'b0, (k <= 7) ? 2'b11 : 2'b00);
      nchk++;
      if (po[1] !== {2{k == 3 || k == 6}}) begin
        nfail++; $display("FAIL repeat_pulse k=%0d got %b required %b", k, po[1], {2{k == 3 || k == 6}});
      end
      nchk++;
      if (ao[1] !== {2{k >= 4}}) begin
        nfail++; $display("FAIL repeat_active k=%0d got %b required %b", k, ao[1], {2{k >= 4}});
      end
      nxt();
    end
    nchk++;
    if (eo[1] !== 16'h0202 || eo[0] !== 16'h0101) begin
      nfail++; $display("FAIL repeat_evt got %h/%h required 0202/0101", eo[1], eo[0]);
    end
  endtask

  task automatic test_hold();
    bit         es [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0] bs [6] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00};
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      put(es[k-1], 1'b0, bs[k-1]);
      nchk++;
      if (po[0] !== {1'b0, k == 5}) begin
        nfail++; $display("FAIL hold_pulse k=%0d got %b required %b", k, po[0], {1'b0, k == 5});
      end
      nchk++;
      if (po[2] !== {1'b0, k == 6}) begin
        nfail++; $display("FAIL hold_moore k=%0d got %b required %b", k, po[2], {1'b0, k == 6});
      end
      nxt();
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int k = 1; k <= 4; k++) begin put(1'b1, 1'b0, 2'b11); nxt(); end
    put(1'b1, 1'b0, 2'b11);
    nchk++;
    if (ao[0] !== 2'b11 || eo[0] !== 16'h0101) begin
      nfail++; $display("FAIL arst_pre active=%b evt=%h required 11/0101", ao[0], eo[0]);
    end
    #2 reset = 1'b1;
    #1;
    for (int c = 0; c < 4; c++) begin
      nchk++;
      if (ao[c] !== 2'b00 || eo[c] !== 16'h0 || po[c] !== 2'b00) begin
        nfail++; $display("FAIL arst cfg%0d active=%b evt=%h pulse=%b required 0", c, ao[c], eo[c], po[c]);
      end
    end
    do_reset();
  endtask

  task automatic test_saturate();
    do_reset();
    for (int k = 1; k <= 7; k++) begin
      put(1'b1, k == 6, 2'b11);
      nchk++;
      if (po[3] !== 2'b11) begin
        nfail++; $display("FAIL sat_pulse k=%0d got %b required 11", k, po[3]);
      end
      nchk++;
      if (eo[3][3:0] !== ((k == 7) ? 4'h0 : {2{2'((k - 1 > 3) ? 3 : k - 1)}})) begin
        nfail++; $display("FAIL sat_evt k=%0d got %h", k, eo[3][3:0]);
      end
      nxt();
    end
  endtask

  task automatic test_random();
    bit h [4][2];
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bit         e, cl;
      logic [1:0] b;
      e  = $urandom_range(3, 0) != 0;
      cl = $urandom_range(24, 0) == 0;
      b  = {$urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0};
      put(e, cl, b);
      for (int c = 0; c < 4; c++)
        for (int ch = 0; ch < 2; ch++) begin
          bit ep;
          h[c][ch] = mhit(c, ch, e, b[ch]);
          ep = ML[c] ? h[c][ch] : phit[c][ch];
          nchk++;
          if (po[c][ch] !== ep || ao[c][ch] !== (run[c][ch] >= RL[c]) || evt_of(c, ch) != evt[c][ch]) begin
            nfail++;
            $display("FAIL rand i=%0d cfg%0d ch%0d pulse=%b/%b active=%b/%b evt=%0d/%0d (got/required)",
                     i, c, ch, po[c][ch], ep, ao[c][ch], run[c][ch] >= RL[c], evt_of(c, ch), evt[c][ch]);
          end
        end
      nxt();
      for (int c = 0; c < 4; c++)
        for (int ch = 0; ch < 2; ch++) begin
          if (cl) evt[c][ch] = 0;
          else if (h[c][ch] && evt[c][ch] < EMAX[c]) evt[c][ch]++;
          phit[c][ch] = h[c][ch];
          if (e) run[c][ch] = b[ch] ? run[c][ch] + 1 : 0;
        end
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_gap();
    test_repeat();
    test_hold();
    test_async_reset();
    test_saturate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
